// File: rtl/wh_rr_allocator_if.sv
// Output-channel bundle for the wormhole round-robin allocator.
// Adds credit_err_o when WH_ALLOC_CREDIT_ERR_EN is defined.
interface wh_rr_allocator_if #(
  parameter int IN_N    = 5,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [IN_N-1:0] req_i;
  logic [IN_N-1:0] data_vld_i;
  logic [IN_N-1:0] flit_id_is_tail_i;
  logic            credit_i;
  logic [IN_N-1:0] grant_o;
  logic            oc_vld_o;
  logic [CW-1:0]   credit_cnt_o;
`ifdef WH_ALLOC_CREDIT_ERR_EN
  logic            credit_err_o;

  modport master (
    output req_i, data_vld_i, flit_id_is_tail_i, credit_i,
    input  grant_o, oc_vld_o, credit_cnt_o, credit_err_o
  );
  modport slave (
    input  req_i, data_vld_i, flit_id_is_tail_i, credit_i,
    output grant_o, oc_vld_o, credit_cnt_o, credit_err_o
  );
`else
  modport master (
    output req_i, data_vld_i, flit_id_is_tail_i, credit_i,
    input  grant_o, oc_vld_o, credit_cnt_o
  );
  modport slave (
    input  req_i, data_vld_i, flit_id_is_tail_i, credit_i,
    output grant_o, oc_vld_o, credit_cnt_o
  );
`endif
endinterface

// File: rtl/wh_rr_allocator.sv
// Wormhole output-channel allocator: round-robin grant held until the owner's tail
// transfers, with downstream credit counting. WH_ALLOC_CREDIT_ERR_EN adds a sticky credit_err_o.
module wh_rr_allocator #(
  parameter int IN_N    = 5,
  parameter int CREDITS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wh_rr_allocator_if.slave  bus
);
  localparam int PW = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IN_N-1:0] grant_q, grant_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [PW-1:0]   cand, win_idx;
  logic            win_found;
  logic            xfer, tail_xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= IN_N) s = s - IN_N;
    return PW'(s);
  endfunction

  assign xfer      = (state_q == LOCKED) && bus.data_vld_i[owner_q] && (credit_q != '0);
  assign tail_xfer = xfer && bus.flit_id_is_tail_i[owner_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      credit_q <= CW'(CREDITS);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    credit_d  = credit_q;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;

    // First requester at or above rr_ptr, wrapping past the top input.
    for (int i = 0; i < IN_N; i++) begin
      cand = wrap_inc(rr_ptr_q, i);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = LOCKED;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_inc(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A returned credit and a consumed one cancel; a surplus credit at full is dropped.
    if (xfer && !bus.credit_i)
      credit_d = credit_q - 1'b1;
    else if (!xfer && bus.credit_i && (credit_q != CW'(CREDITS)))
      credit_d = credit_q + 1'b1;
  end

  assign bus.grant_o      = grant_q;
  assign bus.oc_vld_o     = xfer;
  assign bus.credit_cnt_o = credit_q;

`ifdef WH_ALLOC_CREDIT_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (bus.credit_i && !xfer && (credit_q == CW'(CREDITS)))
      err_q <= 1'b1;
  end

  assign bus.credit_err_o = err_q;
`endif
endmodule

// File: tb/tb_wh_rr_allocator.sv
// Directed and random checks of wh_rr_allocator against an arithmetic reference model.
module tb_wh_rr_allocator;
  localparam int N  = 5;
  localparam int CR = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  wh_rr_allocator_if #(.IN_N(N), .CREDITS(CR)) bus ();

  wh_rr_allocator #(.IN_N(N), .CREDITS(CR)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  logic [N-1:0] cur_req, cur_dv, cur_tl;
  logic         cur_credit;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit exp_vld;
    int exp_grant;
    exp_vld   = m_locked && cur_dv[m_owner] && (m_cred > 0);
    exp_grant = m_locked ? (1 << m_owner) : 0;
    checkValue("grant", 32'(bus.grant_o), 32'(exp_grant));
    checkValue("oc_vld", 32'(bus.oc_vld_o), 32'(exp_vld));
    checkValue("credit_cnt", 32'(bus.credit_cnt_o), 32'(m_cred));
`ifdef WH_ALLOC_CREDIT_ERR_EN
    checkValue("credit_err", 32'(bus.credit_err_o), 32'(m_err));
`endif
    if (bus.oc_vld_o) pulse_cnt++;
  endtask

  // Reference behaviour for the coming rising edge, from the packet-level rules.
  task automatic modelStep();
    bit vld;
    bit found;
    int cand;
    vld = m_locked && cur_dv[m_owner] && (m_cred > 0);
    if (m_locked) begin
      if (vld && cur_tl[m_owner]) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!found && cur_req[cand]) begin
          found    = 1;
          m_locked = 1;
          m_owner  = cand;
        end
      end
    end
    m_cred = m_cred + (cur_credit ? 1 : 0) - (vld ? 1 : 0);
    if (m_cred > CR) begin
      m_cred = CR;
      m_err  = 1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] dv,
                               input logic [N-1:0] tl, input logic c);
    cur_req = r; cur_dv = dv; cur_tl = tl; cur_credit = c;
    bus.req_i = r; bus.data_vld_i = dv; bus.flit_id_is_tail_i = tl; bus.credit_i = c;
    @(negedge clk_i);
    checkOutput();
    modelStep();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyReset();
    cur_req = '0; cur_dv = '0; cur_tl = '0; cur_credit = 1'b0;
    bus.req_i = '0; bus.data_vld_i = '0; bus.flit_id_is_tail_i = '0; bus.credit_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checkValue("rst_grant", 32'(bus.grant_o), 32'd0);
    checkValue("rst_credit", 32'(bus.credit_cnt_o), 32'(CR));
    checkValue("rst_oc_vld", 32'(bus.oc_vld_o), 32'd0);
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CR; m_err = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [N-1:0] r, dv, tl;
    rst_i = 1'b0;
    #2;
    applyReset();

    $display("[TB] round-robin pointer advance");
    applyStimulus(5'b10100, 5'b00000, 5'b00000, 1'b0);
    checkValue("r030_grant_first", 32'(bus.grant_o), 32'b00100);
    applyStimulus(5'b10100, 5'b00100, 5'b00100, 1'b0);
    checkValue("r030_idle", 32'(bus.grant_o), 32'd0);
    applyStimulus(5'b10100, 5'b00000, 5'b00000, 1'b0);
    checkValue("r030_grant_next", 32'(bus.grant_o), 32'b10000);
    applyStimulus(5'b10000, 5'b10000, 5'b10000, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    checkValue("r030_credit_back", 32'(bus.credit_cnt_o), 32'd4);

    $display("[TB] multi-flit packet with valid gaps");
    applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    pulse_cnt = 0;
    applyStimulus(5'b00011, 5'b00000, 5'b00000, 1'b0);
    checkValue("r031_grant", 32'(bus.grant_o), 32'b00010);
    applyStimulus(5'b00011, 5'b00010, 5'b00000, 1'b1);
    applyStimulus(5'b00011, 5'b00000, 5'b00000, 1'b0);
    checkValue("r031_hold", 32'(bus.grant_o), 32'b00010);
    applyStimulus(5'b00011, 5'b00011, 5'b00001, 1'b1);
    applyStimulus(5'b00011, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(5'b00011, 5'b00010, 5'b00010, 1'b1);
    checkValue("r031_released", 32'(bus.grant_o), 32'd0);
    checkValue("r031_pulses", 32'(pulse_cnt), 32'd3);
    applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
    checkValue("r031_next_owner", 32'(bus.grant_o), 32'b00001);
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);

    $display("[TB] credit exhaustion and stall");
    applyReset();
    applyStimulus(5'b00001, 5'b00000, 5'b00000, 1'b0);
    repeat (4) applyStimulus(5'b00001, 5'b00001, 5'b00000, 1'b0);
    checkValue("r032_empty", 32'(bus.credit_cnt_o), 32'd0);
    applyStimulus(5'b00001, 5'b00001, 5'b00000, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 5'b00000, 1'b0);
    checkValue("r032_stall_hold", 32'(bus.grant_o), 32'b00001);
    applyStimulus(5'b00000, 5'b00001, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00001, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00001, 5'b00001, 1'b0);
    checkValue("r032_final_credit", 32'(bus.credit_cnt_o), 32'd0);
    checkValue("r032_released", 32'(bus.grant_o), 32'd0);

    $display("[TB] simultaneous credit and saturation");
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00010, 5'b00000, 5'b00000, 1'b0);
    checkValue("r033_two", 32'(bus.credit_cnt_o), 32'd2);
    applyStimulus(5'b00010, 5'b00010, 5'b00000, 1'b1);
    checkValue("r033_cancel", 32'(bus.credit_cnt_o), 32'd2);
    applyStimulus(5'b00010, 5'b00010, 5'b00010, 1'b0);
    repeat (3) applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 5'b00000, 1'b1);
    checkValue("r033_saturate", 32'(bus.credit_cnt_o), 32'd4);
`ifdef WH_ALLOC_CREDIT_ERR_EN
    checkValue("r033_err", 32'(bus.credit_err_o), 32'd1);
`endif

    $display("[TB] owner drops request mid-packet");
    applyStimulus(5'b01000, 5'b00000, 5'b00000, 1'b0);
    checkValue("r035_grant", 32'(bus.grant_o), 32'b01000);
    applyStimulus(5'b00100, 5'b01000, 5'b00000, 1'b0);
    applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
    checkValue("r035_hold", 32'(bus.grant_o), 32'b01000);
    applyStimulus(5'b00100, 5'b01000, 5'b01000, 1'b1);
    checkValue("r035_released", 32'(bus.grant_o), 32'd0);
    applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
    checkValue("r035_next_owner", 32'(bus.grant_o), 32'b00100);

    $display("[TB] reset mid-packet");
    applyStimulus(5'b01000, 5'b00100, 5'b00100, 1'b1);
    applyStimulus(5'b01000, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(5'b01000, 5'b01000, 5'b00000, 1'b0);
    checkValue("r034_locked", 32'(bus.grant_o), 32'b01000);
    applyReset();
    applyStimulus(5'b01000, 5'b00000, 5'b00000, 1'b0);
    checkValue("r034_regrant", 32'(bus.grant_o), 32'b01000);
    applyStimulus(5'b01000, 5'b01000, 5'b01000, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      r  = N'($urandom);
      dv = N'($urandom);
      tl = N'($urandom & $urandom);
      applyStimulus(r, dv, tl, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wh_rr_allocator.md
WH_RR_ALLOCATOR -- requirements
Module: wh_rr_allocator

Interface
REQ-001 The block SHALL have parameter IN_N, default 5, giving the number of input channels competing for one output channel.
REQ-002 The block SHALL have parameter CREDITS, default 4, giving the downstream buffer depth in flits (>=1).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 Port: rst_i  input  1  asynchronous active-high reset.
REQ-006 Port: req_i  input  IN_N  per-input request for this output channel.
REQ-007 Port: data_vld_i  input  IN_N  per-input flit valid.
REQ-008 Port: flit_id_is_tail_i  input  IN_N  per-input flag marking the presented flit as the packet tail.
REQ-009 Port: credit_i  input  1  one downstream buffer slot freed this cycle.
REQ-010 Port: grant_o  output  IN_N  registered one-hot grant; drives the output mux select.
REQ-011 Port: oc_vld_o  output  1  a flit transfers to the output channel this cycle.
REQ-012 Port: credit_cnt_o  output  $clog2(CREDITS+1)  current available downstream credits.

Function
REQ-013 FSM states SHALL be IDLE (grant_o all zero) and LOCKED (grant_o one-hot, owner held).
REQ-014 In IDLE with any req_i bit set, the winner SHALL be the first set bit searching upward from rr_ptr with wrap from IN_N-1 to 0; next cycle grant_o = one-hot winner, state LOCKED.
REQ-015 In IDLE with req_i all zero, state and grant_o SHALL remain unchanged.
REQ-016 Grant latency SHALL be exactly one cycle: request sampled at edge t, grant_o valid after edge t+1.
REQ-017 oc_vld_o SHALL be combinational: 1 iff state LOCKED, data_vld_i[owner]=1 and credit_cnt_o>0.
REQ-018 In LOCKED the owner SHALL be held regardless of req_i changes, including the owner deasserting req_i, until its tail transfers.
REQ-019 A transfer with flit_id_is_tail_i[owner]=1 SHALL move state to IDLE, clear grant_o, and set rr_ptr = (owner+1) mod IN_N on the same edge.
REQ-020 A single-flit packet (tail on first flit) SHALL be handled by REQ-019; no separate head handling.
REQ-021 After a tail transfer at edge t, the earliest new grant SHALL be after edge t+2 (one IDLE cycle minimum).
REQ-022 credit_cnt_o SHALL decrement by 1 on a transfer, increment by 1 on credit_i, and be unchanged when both occur in the same cycle.
REQ-023 At credit_cnt_o=0 no transfer SHALL occur; the lock is held and the flit stalls.
REQ-024 credit_i while credit_cnt_o=CREDITS with no simultaneous transfer SHALL be ignored (saturate at CREDITS).
REQ-025 data_vld_i and flit_id_is_tail_i of non-owner inputs SHALL have no effect.

Reset
REQ-026 While rst_i=1, asynchronously: state IDLE, grant_o=0, rr_ptr=0, credit_cnt_o=CREDITS, oc_vld_o=0.
REQ-027 Reset mid-packet SHALL abandon the lock with no tail required; after release, arbitration restarts from input 0.

Configuration
REQ-028 Macro WH_ALLOC_CREDIT_ERR_EN defined: extra port credit_err_o output 1, sticky flag set on the edge after a credit_i ignored per REQ-024 and cleared only by reset (reset value 0).
REQ-029 Macro WH_ALLOC_CREDIT_ERR_EN undefined: credit_err_o port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-030 IN_N=5, rr_ptr=0, req_i=5'b10100 held -> grant_o=5'b00100 after one cycle; after its tail, rr_ptr=3, next grant_o=5'b10000.
REQ-031 Owner input 1 sends 3 flits (tail on third) with data_vld_i gaps while input 0 requests -> grant_o stays 5'b00010 for all 3 transfers; 3 oc_vld_o pulses; input 0 granted two cycles after the tail edge.
REQ-032 CREDITS=4, no credit_i, owner sends 6-flit packet -> oc_vld_o for 4 flits, credit_cnt_o=0, stall; two credit_i pulses -> remaining 2 flits transfer, credit_cnt_o=0.
REQ-033 credit_cnt_o=2, transfer and credit_i in same cycle -> credit_cnt_o stays 2; credit_i at credit_cnt_o=4 -> stays 4, credit_err_o=1 when macro defined.
REQ-034 rst_i asserted mid-packet with owner input 3 -> grant_o=0, credit_cnt_o=4 immediately; after release, req_i=5'b01000 -> grant_o=5'b01000 after one cycle.
REQ-035 Owner deasserts req_i mid-packet while input 2 requests -> lock held; input 2 granted only after owner tail.
